riscv_lsu_byteseq: RTL and testbench
====================================

# riscv_lsu_byteseq

Load/store sequencer between the core's memory stage and the byte-wide, single-write-port data BRAM. It turns one RV32I load or store (byte, halfword, word) into 1, 2 or 4 sequential byte accesses. Memory is little-endian. Loads are sign- or zero-extended and returned as one 32-bit response.

## Interface
- ADDR_LENGTH, 32, width of byte addresses on both the core and memory sides
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  core presents a memory request
- req_ready  out  1  sequencer can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (size/sign)
- req_addr  in  ADDR_LENGTH  byte address of lowest byte
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  one-cycle pulse: request complete
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid: request rejected, no memory access
- mem_write_en  out  1  byte write strobe to BRAM
- mem_waddr  out  ADDR_LENGTH  BRAM write address
- mem_wdata  out  8  BRAM write byte
- mem_raddr  out  ADDR_LENGTH  BRAM read address
- mem_dout  in  8  BRAM read byte (combinational from mem_raddr)

## Operation
- States: IDLE, ACCESS, DONE. Registers: base address, byte index i (0..3), byte count n, op, funct3, store data, assembled read data, error flag.
- Accepting a request: when req_valid && req_ready at a rising edge, the request fields are captured and i is set to 0.
  - A valid request goes to ACCESS.
  - An invalid request goes to DONE with the error flag set.
- Valid loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Valid stores: funct3 000 SB, 001 SH, 010 SW.
- Every other funct3 is invalid: 011, 110 and 111 for either operation, plus 100 and 101 for stores.
- Byte count n is 1, 2 or 4, set by funct3[1:0].
- ACCESS, one byte per cycle. The address is (base + i) mod 2^ADDR_LENGTH and drives both mem_raddr and mem_waddr.
  - Store: mem_write_en = 1 and mem_wdata = store_data[8i+7:8i].
  - Load: mem_write_en = 0, and mem_dout is captured into byte i of the read register at the rising edge.
  - i increments each cycle. After byte n-1 the state goes to DONE.
- DONE: resp_valid = 1 for exactly one cycle, then the state returns to IDLE.
  - resp_rdata (loads only) is extended from bit 8n-1: sign-extended for LB/LH, zero-extended for LBU/LHU, unchanged for LW.
- Outside ACCESS, mem_write_en = 0 and mem_raddr/mem_waddr hold the last address driven.
- resp_rdata and resp_err are valid only while resp_valid is high. Between responses they hold their values from the last response.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_write_en 0, mem_waddr 0, mem_raddr 0, mem_wdata 0.
- Reset mid-operation: the state returns to IDLE immediately and mem_write_en drops asynchronously.
  - Bytes already written stay in memory.
  - No response is issued for the aborted request.
- There is no back-pressure on responses; the core always accepts resp_valid.

## Timing
- A request accepted at edge T0 produces ACCESS cycles T0+1 … T0+n.
- resp_valid is high in cycle T0+n+1, so a valid request has a latency of n+1 cycles: LB/SB 2, LH/SH 3, LW/SW 5.
- An error request has resp_valid in cycle T0+1.
- req_ready is high again in cycle T0+n+2; the earliest next accept is at the end of that cycle.
- Store byte i is written at the rising edge that ends ACCESS cycle i.
- A load issued immediately after a store sees all bytes of that store.

## Configuration
- Macro: RISCV_LSU_MISALIGN_CHECK_EN.
- Defined: a halfword with addr[0] ≠ 0, or a word with addr[1:0] ≠ 0, is an error.
  - The request goes straight to DONE with resp_err = 1 and resp_rdata = 0.
  - No memory access is made.
- Undefined: misaligned accesses are performed byte-wise like any other. Address wrap past 2^ADDR_LENGTH-1 goes to 0.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → memory bytes 0x10..0x13 = EF, BE, AD, DE.
  - resp_rdata = 0xDEADBEEF; resp_valid 5 cycles after each accept; resp_err = 0.
- Byte 0x20 = 0x80, then LB @0x20 → resp_rdata = 0xFFFFFF80. LBU @0x20 → 0x00000080.
- SH 0x1234 @0x31 with the macro defined → resp_err = 1 one cycle after accept; mem_write_en never asserted.
  - Same request with the macro undefined → bytes 0x31 = 34, 0x32 = 12; resp_err = 0.
- Load with funct3 = 011, and store with funct3 = 100 → resp_err = 1, resp_rdata = 0, latency 1; no memory access.
- SW 0xA1B2C3D4 @0x40 with rst asserted after 2 ACCESS cycles:
  - Bytes 0x40 = D4 and 0x41 = C3 written; 0x42 and 0x43 unchanged.
  - No resp_valid; req_ready = 1 immediately after reset.
- Back-to-back: req_valid held high with two LH requests.
  - The second is accepted only when req_ready returns, 4 cycles after the first accept.
  - Both responses are correct.

Source files
------------

// File: rtl/riscv_lsu_byteseq.sv
// riscv_lsu_byteseq
//   Load/store sequencer between the core memory stage and a byte-wide,
//   single-write-port data BRAM. Each RV32I load or store (B/H/W) becomes
//   1, 2 or 4 sequential byte accesses, little-endian. Loads are sign- or
//   zero-extended and returned as one 32-bit response.
//
//   Optional feature macro: RISCV_LSU_MISALIGN_CHECK_EN
//     defined   : misaligned halfword/word requests are rejected with resp_err
//     undefined : misaligned requests are performed byte-wise (address wraps)
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_we              1 = store, 0 = load
//   req_funct3          RV32I funct3 (size / sign)
//   req_addr            byte address of lowest byte
//   req_wdata           store data, LSB-aligned
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load data (0 for stores and errors)
//   resp_err            request rejected, no memory access made
//   mem_write_en        BRAM byte write strobe
//   mem_waddr/mem_wdata BRAM write address / byte
//   mem_raddr           BRAM read address
//   mem_dout            BRAM read byte (combinational from mem_raddr)
module riscv_lsu_byteseq #(
  parameter int ADDR_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [2:0]             req_funct3,
  input  logic [ADDR_LENGTH-1:0] req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   resp_valid,
  output logic [31:0]            resp_rdata,
  output logic                   resp_err,
  output logic                   mem_write_en,
  output logic [ADDR_LENGTH-1:0] mem_waddr,
  output logic [7:0]             mem_wdata,
  output logic [ADDR_LENGTH-1:0] mem_raddr,
  input  logic [7:0]             mem_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_LENGTH-1:0] base_q, base_d;
  logic [ADDR_LENGTH-1:0] addr_hold_q, addr_hold_d;
  logic [1:0]             idx_q, idx_d;
  logic                   we_q, we_d;
  logic [2:0]             funct3_q, funct3_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [31:0]            resp_rdata_q, resp_rdata_d;
  logic                   resp_err_q, resp_err_d;
  logic [7:0]             wbyte_q, wbyte_d;

  logic                   in_access;
  logic [ADDR_LENGTH-1:0] cur_addr;
  logic [7:0]             cur_wbyte;
  logic [1:0]             last_idx;
  logic                   req_ok;
  logic [31:0]            rdata_next;

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  extend = {{24{d[7]}}, d[7:0]};
      3'b001:  extend = {{16{d[15]}}, d[15:0]};
      3'b100:  extend = {24'h0, d[7:0]};
      3'b101:  extend = {16'h0, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  // Legality of the incoming request, including the optional alignment rule.
  always_comb begin
    req_ok = 1'b0;
    if (req_we) begin
      req_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      req_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
               (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    end
`ifdef RISCV_LSU_MISALIGN_CHECK_EN
    if ((req_funct3[1:0] == 2'b01) && req_addr[0]) req_ok = 1'b0;
    if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) req_ok = 1'b0;
`endif
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  assign in_access = (state_q == ACCESS);
  assign cur_addr  = base_q + ADDR_LENGTH'(idx_q);
  assign cur_wbyte = wdata_q[{idx_q, 3'b000} +: 8];

  always_comb begin
    rdata_next = rdata_q;
    rdata_next[{idx_q, 3'b000} +: 8] = mem_dout;
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    addr_hold_d  = addr_hold_q;
    idx_d        = idx_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    wbyte_d      = wbyte_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          base_d   = req_addr;
          idx_d    = 2'd0;
          we_d     = req_we;
          funct3_d = req_funct3;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          if (req_ok) begin
            state_d = ACCESS;
          end else begin
            // Error responses are fully decided here; a valid request leaves
            // the previous response values in place until it completes.
            state_d      = DONE;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end
        end
      end
      ACCESS: begin
        addr_hold_d = cur_addr;
        if (we_q) wbyte_d = cur_wbyte;
        else      rdata_d = rdata_next;
        idx_d = idx_q + 2'd1;
        if (idx_q == last_idx) begin
          state_d      = DONE;
          resp_err_d   = 1'b0;
          resp_rdata_d = we_q ? 32'h0 : extend(funct3_q, rdata_next);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      base_q       <= '0;
      addr_hold_q  <= '0;
      idx_q        <= '0;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      wbyte_q      <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      addr_hold_q  <= addr_hold_d;
      idx_q        <= idx_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      wbyte_q      <= wbyte_d;
    end
  end

  // Memory-side outputs are decoded from state so an asynchronous reset
  // drops the write strobe immediately; addresses/data hold when not accessing.
  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == DONE);
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign mem_write_en = in_access && we_q;
  assign mem_raddr    = in_access ? cur_addr : addr_hold_q;
  assign mem_waddr    = in_access ? cur_addr : addr_hold_q;
  assign mem_wdata    = (in_access && we_q) ? cur_wbyte : wbyte_q;

endmodule

// File: tb/tb_riscv_lsu_byteseq.sv
module tb_riscv_lsu_byteseq;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write_en;
  logic [31:0] mem_waddr;
  logic [7:0]  mem_wdata;
  logic [31:0] mem_raddr;
  logic [7:0]  mem_dout;

  int checks;
  int failures;

  logic [7:0] mem [256];

  riscv_lsu_byteseq #(.ADDR_LENGTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_write_en(mem_write_en), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-wide BRAM model, 256 bytes, addresses aliased on the low byte.
  always @(posedge clk) if (mem_write_en) mem[mem_waddr[7:0]] <= mem_wdata;
  assign mem_dout = mem[mem_raddr[7:0]];

  // Presents one request, releases req_valid after acceptance, then counts
  // cycles after the accept edge until resp_valid (lat = -1 on timeout).
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int lat, output logic [31:0] rd,
                       output logic er, output int nwr);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1; nwr = 0; rd = 32'h0; er = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_write_en) nwr++;
      if (resp_valid) begin
        lat = c; rd = resp_rdata; er = resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", resp_err); end
    checks++; if (mem_write_en !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", mem_write_en); end
    checks++; if (mem_waddr !== 32'h0 || mem_raddr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h/%h exp=0", mem_waddr, mem_raddr); end
    checks++; if (mem_wdata !== 8'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", mem_wdata); end
  endtask

  task automatic test_sw_lw();
    int lat, nwr; logic [31:0] rd; logic er;
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, er, nwr);
    checks++; if (lat !== 5) begin failures++; $display("FAIL sw_lat got=%0d exp=5", lat); end
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL sw_resp got=%b/%h exp=0/0", er, rd); end
    checks++; if (nwr !== 4) begin failures++; $display("FAIL sw_nwr got=%0d exp=4", nwr); end
    checks++;
    if ({mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} !== 32'hDEADBEEF) begin
      failures++; $display("FAIL sw_mem got=%h %h %h %h exp=EF BE AD DE", mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]);
    end
    issue(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er, nwr);
    checks++; if (lat !== 5) begin failures++; $display("FAIL lw_lat got=%0d exp=5", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata got=%h exp=deadbeef", rd); end
    checks++; if (er !== 1'b0 || nwr !== 0) begin failures++; $display("FAIL lw_err got=%b/%0d exp=0/0", er, nwr); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_hold got=%b/%h exp=0/deadbeef", resp_valid, resp_rdata); end
    checks++; if (mem_raddr !== 32'h13) begin failures++; $display("FAIL lw_addr_hold got=%h exp=13", mem_raddr); end
  endtask

  task automatic test_byte_ext();
    int lat, nwr; logic [31:0] rd; logic er;
    issue(1'b1, 3'b000, 32'h20, 32'hFFFFFF80, lat, rd, er, nwr);
    checks++; if (lat !== 2 || nwr !== 1) begin failures++; $display("FAIL sb_lat got=%0d/%0d exp=2/1", lat, nwr); end
    checks++; if (mem[8'h20] !== 8'h80 || mem[8'h21] !== 8'h00) begin failures++; $display("FAIL sb_mem got=%h %h exp=80 00", mem[8'h20], mem[8'h21]); end
    issue(1'b0, 3'b000, 32'h20, 32'h0, lat, rd, er, nwr);
    checks++; if (lat !== 2 || rd !== 32'hFFFFFF80) begin failures++; $display("FAIL lb got=%0d/%h exp=2/ffffff80", lat, rd); end
    issue(1'b0, 3'b100, 32'h20, 32'h0, lat, rd, er, nwr);
    checks++; if (lat !== 2 || rd !== 32'h00000080) begin failures++; $display("FAIL lbu got=%0d/%h exp=2/00000080", lat, rd); end
    issue(1'b0, 3'b101, 32'h10, 32'h0, lat, rd, er, nwr);
    checks++; if (lat !== 3 || rd !== 32'h0000BEEF) begin failures++; $display("FAIL lhu got=%0d/%h exp=3/0000beef", lat, rd); end
  endtask

  task automatic test_misalign();
    int lat, nwr; logic [31:0] rd; logic er;
    issue(1'b1, 3'b001, 32'h31, 32'h00001234, lat, rd, er, nwr);
`ifdef RISCV_LSU_MISALIGN_CHECK_EN
    checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL sh_mis got=%0d/%b/%h exp=1/1/0", lat, er, rd); end
    checks++; if (nwr !== 0 || mem[8'h31] !== 8'h00 || mem[8'h32] !== 8'h00) begin failures++; $display("FAIL sh_mis_mem got=%0d %h %h exp=0 00 00", nwr, mem[8'h31], mem[8'h32]); end
`else
    checks++; if (lat !== 3 || er !== 1'b0) begin failures++; $display("FAIL sh_mis got=%0d/%b exp=3/0", lat, er); end
    checks++; if (nwr !== 2 || mem[8'h31] !== 8'h34 || mem[8'h32] !== 8'h12) begin failures++; $display("FAIL sh_mis_mem got=%0d %h %h exp=2 34 12", nwr, mem[8'h31], mem[8'h32]); end
`endif
    issue(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000BEEF, lat, rd, er, nwr);
`ifdef RISCV_LSU_MISALIGN_CHECK_EN
    checks++; if (lat !== 1 || er !== 1'b1 || nwr !== 0) begin failures++; $display("FAIL sh_wrap got=%0d/%b/%0d exp=1/1/0", lat, er, nwr); end
`else
    checks++; if (lat !== 3 || er !== 1'b0 || mem[8'hFF] !== 8'hEF || mem[8'h00] !== 8'hBE) begin
      failures++; $display("FAIL sh_wrap got=%0d/%b %h %h exp=3/0 ef be", lat, er, mem[8'hFF], mem[8'h00]);
    end
`endif
  endtask

  task automatic test_invalid();
    int lat, nwr; logic [31:0] rd; logic er;
    issue(1'b0, 3'b011, 32'h10, 32'h0, lat, rd, er, nwr);
    checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || nwr !== 0) begin failures++; $display("FAIL ld_f3_011 got=%0d/%b/%h/%0d exp=1/1/0/0", lat, er, rd, nwr); end
    issue(1'b1, 3'b100, 32'h50, 32'h000000AA, lat, rd, er, nwr);
    checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || nwr !== 0) begin failures++; $display("FAIL st_f3_100 got=%0d/%b/%h/%0d exp=1/1/0/0", lat, er, rd, nwr); end
    checks++; if (mem[8'h50] !== 8'h00) begin failures++; $display("FAIL st_f3_100_mem got=%h exp=00", mem[8'h50]); end
  endtask

  task automatic test_reset_mid();
    int seen;
    for (int k = 0; k < 4; k++) mem[8'h40 + k] = 8'h11;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'hA1B2C3D4;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (mem_write_en !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_async got=%b/%b exp=0/1", mem_write_en, req_ready); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rst_mid_resp got=%0d exp=0", seen); end
    checks++;
    if (mem[8'h40] !== 8'hD4 || mem[8'h41] !== 8'hC3 || mem[8'h42] !== 8'h11 || mem[8'h43] !== 8'h11) begin
      failures++; $display("FAIL rst_mid_mem got=%h %h %h %h exp=d4 c3 11 11", mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]);
    end
  endtask

  task automatic test_back_to_back();
    int acc, lat2;
    logic [31:0] r1, r2;
    acc = -1; lat2 = -1; r1 = 32'h0; r2 = 32'h0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b001; req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk);
    #1 req_addr = 32'h12;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (resp_valid) r1 = resp_rdata;
      if (req_ready) begin acc = c; break; end
    end
    checks++; if (acc !== 4) begin failures++; $display("FAIL b2b_accept got=%0d exp=4", acc); end
    checks++; if (r1 !== 32'hFFFFBEEF) begin failures++; $display("FAIL b2b_r1 got=%h exp=ffffbeef", r1); end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (resp_valid) begin lat2 = c; r2 = resp_rdata; break; end
    end
    checks++; if (lat2 !== 3 || r2 !== 32'hFFFFDEAD) begin failures++; $display("FAIL b2b_r2 got=%0d/%h exp=3/ffffdead", lat2, r2); end
  endtask

  initial begin
    checks = 0; failures = 0;
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    @(negedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_sw_lw();
    test_byte_ext();
    test_misalign();
    test_invalid();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
